// File: rtl/pkt_tx_pkg.sv
// Shared types for the packet transmitter slice.
// PKT_TX_CSUM_EN (optional) appends a checksum word to every packet.
package pkt_tx_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic cnst;
        logic err;
    } cmd_ctl_t;

endpackage

// File: rtl/pkt_tx_payload.sv
// Payload word counter, pattern generator and optional checksum accumulator.
// PKT_TX_CSUM_EN builds the running sum and exposes done/sum.
module pkt_tx_payload
    import pkt_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              cnst,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] start,
    output logic [DATA_W-1:0] word,
    output logic              last
`ifdef PKT_TX_CSUM_EN
    ,
    output logic              done,
    output logic [DATA_W-1:0] sum
`endif
);

    logic [DATA_W-1:0] cur;
    logic [LEN_W-1:0]  left;
    logic [LEN_W-1:0]  left_n;
    logic [LEN_W-1:0]  len_eff;

    assign len_eff = (len == '0) ? LEN_W'(1) : len;

    // word is the value emitted at the coming edge; left counts words after it
    always_comb begin
        word   = cnst ? cur : cur + DATA_W'(1);
        left_n = left - LEN_W'(1);
        if (load) begin
            word   = start;
            left_n = len_eff - LEN_W'(1);
        end
    end

    assign last = (left_n == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= '0;
            left <= '0;
        end else if (load || step) begin
            cur  <= word;
            left <= left_n;
        end
    end

`ifdef PKT_TX_CSUM_EN
    logic [DATA_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (load || step) begin
            acc <= load ? word : acc + word;
        end
    end

    assign sum  = acc;
    assign done = (left == '0);
`endif

endmodule

// File: rtl/pkt_tx_gen.sv
// Packet transmitter: command handshake, framing FSM, inter-packet gap, pkt_cnt.
// PKT_TX_CSUM_EN appends a checksum word carrying eop/err.
module pkt_tx_gen
    import pkt_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_start,
    input  logic              cmd_const,
    input  logic              cmd_err,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic              dout_err,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic [15:0]       pkt_cnt
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t            state, state_n;
    cmd_ctl_t          ctl, ctl_n;
    logic [GW-1:0]     gap_cnt, gap_n;
    logic              vld_n, sop_n, eop_n, err_n;
    logic [DATA_W-1:0] dout_n;
    logic [15:0]       cnt_n;
    logic              load, step;
    logic [DATA_W-1:0] pay_word;
    logic              pay_last;
`ifdef PKT_TX_CSUM_EN
    logic              pay_done;
    logic [DATA_W-1:0] pay_sum;
`endif

    pkt_tx_payload #(
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) u_payload (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .cnst (ctl.cnst),
        .len  (cmd_len),
        .start(cmd_start),
        .word (pay_word),
        .last (pay_last)
`ifdef PKT_TX_CSUM_EN
        ,
        .done (pay_done),
        .sum  (pay_sum)
`endif
    );

    assign cmd_rdy = (state == ST_IDLE);
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        ctl_n   = ctl;
        gap_n   = gap_cnt;
        cnt_n   = pkt_cnt;
        vld_n   = 1'b0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        err_n   = 1'b0;
        dout_n  = '0;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_vld) begin
                    load    = 1'b1;
                    ctl_n   = '{cnst: cmd_const, err: cmd_err};
                    state_n = ST_SEND;
                    vld_n   = 1'b1;
                    sop_n   = 1'b1;
                    dout_n  = pay_word;
`ifndef PKT_TX_CSUM_EN
                    eop_n   = pay_last;
`endif
                    err_n   = eop_n & cmd_err;
                end
            end
            ST_SEND: begin
                // dout_eop high means the word on the bus closes the packet
                if (dout_eop) begin
                    if (GAP > 0) begin
                        state_n = ST_GAP;
                        gap_n   = GW'(GAP - 1);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    vld_n = 1'b1;
`ifdef PKT_TX_CSUM_EN
                    if (pay_done) begin
                        dout_n = pay_sum;
                        eop_n  = 1'b1;
                    end else begin
                        step   = 1'b1;
                        dout_n = pay_word;
                    end
`else
                    step   = 1'b1;
                    dout_n = pay_word;
                    eop_n  = pay_last;
`endif
                    err_n = eop_n & ctl.err;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_n = gap_cnt - GW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (eop_n) begin
            cnt_n = pkt_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ctl      <= '0;
            gap_cnt  <= '0;
            pkt_cnt  <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_err <= 1'b0;
            dout     <= '0;
        end else begin
            state    <= state_n;
            ctl      <= ctl_n;
            gap_cnt  <= gap_n;
            pkt_cnt  <= cnt_n;
            dout_vld <= vld_n;
            dout_sop <= sop_n;
            dout_eop <= eop_n;
            dout_err <= err_n;
            dout     <= dout_n;
        end
    end

endmodule

// File: tb/tb_pkt_tx_gen.sv
// Directed self-checking bench for pkt_tx_gen.
// Build with PKT_TX_CSUM_EN defined to exercise the checksum word.
module tb_pkt_tx_gen;

    localparam int DW  = 16;
    localparam int LW  = 8;
    localparam int GAP = 2;
`ifdef PKT_TX_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef logic [DW-1:0] wq_t[$];

    logic          clk;
    logic          rst;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_start;
    logic          cmd_const;
    logic          cmd_err;
    logic          dout_vld;
    logic          dout_sop;
    logic          dout_eop;
    logic          dout_err;
    logic [DW-1:0] dout;
    logic          busy;
    logic [15:0]   pkt_cnt;

    int nvec = 0;
    int nmis = 0;
    int exp_cnt = 0;

    wq_t         cap;
    int          n_sop, err_bad, junk;
    logic        sop_first, eop_seen, err_eop, rdy_seen;
    logic [15:0] cnt_eop;

    pkt_tx_gen #(
        .DATA_W(DW),
        .LEN_W (LW),
        .GAP   (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_len  (cmd_len),
        .cmd_start(cmd_start),
        .cmd_const(cmd_const),
        .cmd_err  (cmd_err),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_err (dout_err),
        .dout     (dout),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference packet: payload pattern plus optional checksum word
    function automatic wq_t build_exp(int len, logic [DW-1:0] st, logic c);
        wq_t q;
        logic [DW-1:0] s, w;
        int leff;
        leff = (len == 0) ? 1 : len;
        s = '0;
        for (int k = 0; k < leff; k++) begin
            w = c ? st : st + DW'(k);
            q.push_back(w);
            s = s + w;
        end
        if (CS == 1) q.push_back(s);
        return q;
    endfunction

    task automatic issue(int len, logic [DW-1:0] st, logic c, logic e);
        int g;
        g = 0;
        while (!cmd_rdy && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!cmd_rdy) begin
            nvec++; nmis++;
            $display("FAIL issue_rdy: cmd_rdy=%b after %0d cycles, required 1", cmd_rdy, g);
        end
        cmd_len = LW'(len); cmd_start = st; cmd_const = c; cmd_err = e;
        cmd_vld = 1'b1;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    task automatic collect();
        cap.delete();
        n_sop = 0; err_bad = 0; junk = 0;
        sop_first = 0; eop_seen = 0; err_eop = 0; rdy_seen = 0; cnt_eop = '0;
        for (int g = 0; g < 400; g++) begin
            if (cmd_rdy) rdy_seen = 1;
            if (dout_vld) begin
                if (dout_sop) begin
                    n_sop++;
                    if (cap.size() == 0) sop_first = 1;
                end
                if (dout_err && !dout_eop) err_bad++;
                cap.push_back(dout);
                if (dout_eop) begin
                    eop_seen = 1; err_eop = dout_err; cnt_eop = pkt_cnt;
                    break;
                end
            end else if (dout_sop || dout_eop || dout_err || dout != 0 || cap.size() != 0) begin
                junk++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({cmd_rdy, dout_vld, dout_sop, dout_eop, dout_err, busy} !== 6'b100000) begin
            nmis++;
            $display("FAIL rst_flags: rdy,vld,sop,eop,err,busy=%b required 100000",
                {cmd_rdy, dout_vld, dout_sop, dout_eop, dout_err, busy});
        end
        nvec++;
        if (dout !== 16'h0 || pkt_cnt !== 16'h0) begin
            nmis++;
            $display("FAIL rst_data: dout=%h pkt_cnt=%0d required 0/0", dout, pkt_cnt);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        wq_t ex;
        int bad;
        issue(20, 16'h0100, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        nvec++;
        if (dout !== 16'h0104 || busy !== 1'b1 || dout_vld !== 1'b1) begin
            nmis++;
            $display("FAIL mrst_word5: dout=%h busy=%b vld=%b required 0104/1/1", dout, busy, dout_vld);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nvec++;
        if (dout_vld !== 1'b0 || cmd_rdy !== 1'b1 || dout_eop !== 1'b0) begin
            nmis++;
            $display("FAIL mrst_after: vld=%b rdy=%b eop=%b required 0/1/0", dout_vld, cmd_rdy, dout_eop);
        end
        nvec++;
        if (pkt_cnt !== 16'(exp_cnt)) begin
            nmis++;
            $display("FAIL mrst_cnt: pkt_cnt=%0d required %0d", pkt_cnt, exp_cnt);
        end
        issue(3, 16'h0007, 1'b0, 1'b0);
        collect();
        exp_cnt++;
        ex = build_exp(3, 16'h0007, 1'b0);
        bad = 0;
        for (int k = 0; k < cap.size() && k < ex.size(); k++) if (cap[k] !== ex[k]) bad++;
        nvec++;
        if (bad != 0 || cap.size() != ex.size() || !sop_first || n_sop != 1 || !eop_seen) begin
            nmis++;
            $display("FAIL mrst_next: words=%0d bad=%0d sop_first=%b nsop=%0d eop=%b required %0d/0/1/1/1",
                cap.size(), bad, sop_first, n_sop, eop_seen, ex.size());
        end
        nvec++;
        if (cnt_eop !== 16'(exp_cnt)) begin
            nmis++;
            $display("FAIL mrst_next_cnt: pkt_cnt=%0d required %0d", cnt_eop, exp_cnt);
        end
    endtask

    task automatic test_incr();
        wq_t ex;
        int bad;
        issue(12, 16'h0001, 1'b0, 1'b0);
        collect();
        exp_cnt++;
        ex = build_exp(12, 16'h0001, 1'b0);
        bad = 0;
        for (int k = 0; k < cap.size() && k < ex.size(); k++) if (cap[k] !== ex[k]) bad++;
        nvec++;
        if (bad != 0 || cap.size() != ex.size()) begin
            nmis++;
            $display("FAIL incr_words: got %0d words, %0d wrong, required %0d", cap.size(), bad, ex.size());
        end
        nvec++;
        if (!sop_first || n_sop != 1 || !eop_seen || err_eop || junk != 0) begin
            nmis++;
            $display("FAIL incr_frame: sop_first=%b nsop=%0d eop=%b err=%b junk=%0d required 1/1/1/0/0",
                sop_first, n_sop, eop_seen, err_eop, junk);
        end
        nvec++;
        if (cnt_eop !== 16'(exp_cnt)) begin
            nmis++;
            $display("FAIL incr_cnt: pkt_cnt=%0d required %0d", cnt_eop, exp_cnt);
        end
    endtask

    task automatic test_err_gap();
        wq_t ex;
        int bad;
        issue(100, 16'h0000, 1'b0, 1'b1);
        collect();
        exp_cnt++;
        ex = build_exp(100, 16'h0000, 1'b0);
        bad = 0;
        for (int k = 0; k < cap.size() && k < ex.size(); k++) if (cap[k] !== ex[k]) bad++;
        nvec++;
        if (bad != 0 || cap.size() != ex.size()) begin
            nmis++;
            $display("FAIL err_words: got %0d words, %0d wrong, required %0d", cap.size(), bad, ex.size());
        end
        nvec++;
        if (err_bad != 0 || err_eop !== 1'b1 || !eop_seen) begin
            nmis++;
            $display("FAIL err_flag: err_off_eop=%0d err_on_eop=%b required 0/1", err_bad, err_eop);
        end
        nvec++;
        if (rdy_seen !== 1'b0 || junk != 0) begin
            nmis++;
            $display("FAIL err_rdy: rdy_seen=%b holes=%0d required 0/0", rdy_seen, junk);
        end
        nvec++;
        if (cnt_eop !== 16'(exp_cnt)) begin
            nmis++;
            $display("FAIL err_cnt: pkt_cnt=%0d required %0d", cnt_eop, exp_cnt);
        end
    endtask

    task automatic test_const();
        int bad;
        issue(90, 16'h0000, 1'b1, 1'b0);
        collect();
        exp_cnt++;
        bad = 0;
        for (int k = 0; k < cap.size() - CS; k++) if (cap[k] !== 16'h0000) bad++;
        nvec++;
        if (bad != 0 || cap.size() != 90 + CS) begin
            nmis++;
            $display("FAIL const_words: got %0d words, %0d nonzero, required %0d", cap.size(), bad, 90 + CS);
        end
        nvec++;
        if (n_sop != 1 || !eop_seen || !sop_first || cnt_eop !== 16'(exp_cnt)) begin
            nmis++;
            $display("FAIL const_frame: nsop=%0d eop=%b cnt=%0d required 1/1/%0d", n_sop, eop_seen, cnt_eop, exp_cnt);
        end
    endtask

    task automatic test_wrap_short();
        wq_t ex;
        int bad;
        issue(4, 16'hFFFE, 1'b0, 1'b0);
        collect();
        exp_cnt++;
        ex.delete();
        ex.push_back(16'hFFFE); ex.push_back(16'hFFFF);
        ex.push_back(16'h0000); ex.push_back(16'h0001);
        if (CS == 1) ex.push_back(16'hFFFE);
        bad = 0;
        for (int k = 0; k < cap.size() && k < ex.size(); k++) if (cap[k] !== ex[k]) bad++;
        nvec++;
        if (bad != 0 || cap.size() != ex.size() || cnt_eop !== 16'(exp_cnt)) begin
            nmis++;
            $display("FAIL wrap_words: got %0d words, %0d wrong, cnt=%0d required %0d/0/%0d",
                cap.size(), bad, cnt_eop, ex.size(), exp_cnt);
        end
        issue(1, 16'h0055, 1'b0, 1'b1);
        collect();
        exp_cnt++;
        nvec++;
        if (cap.size() != 1 + CS || cap[0] !== 16'h0055 || !sop_first || !eop_seen || err_eop !== 1'b1) begin
            nmis++;
            $display("FAIL len1: words=%0d w0=%h sop=%b eop=%b err=%b required %0d/0055/1/1/1",
                cap.size(), cap[0], sop_first, eop_seen, err_eop, 1 + CS);
        end
        issue(0, 16'h00AA, 1'b0, 1'b0);
        collect();
        exp_cnt++;
        nvec++;
        if (cap.size() != 1 + CS || cap[0] !== 16'h00AA || !sop_first || !eop_seen || err_eop) begin
            nmis++;
            $display("FAIL len0: words=%0d w0=%h sop=%b eop=%b err=%b required %0d/00aa/1/1/0",
                cap.size(), cap[0], sop_first, eop_seen, err_eop, 1 + CS);
        end
        nvec++;
        if (cnt_eop !== 16'(exp_cnt)) begin
            nmis++;
            $display("FAIL len0_cnt: pkt_cnt=%0d required %0d", cnt_eop, exp_cnt);
        end
    endtask

    // cmd_vld held high: second packet must wait GAP cycles plus one IDLE cycle
    task automatic test_back_to_back();
        wq_t ex;
        int bad, d;
        int g;
        g = 0;
        while (!cmd_rdy && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        cmd_len = 8'd3; cmd_start = 16'h0020; cmd_const = 1'b0; cmd_err = 1'b0;
        cmd_vld = 1'b1;
        @(posedge clk); #1;
        collect();
        exp_cnt++;
        nvec++;
        if (n_sop != 1 || cap.size() != 3 + CS || cnt_eop !== 16'(exp_cnt)) begin
            nmis++;
            $display("FAIL b2b_first: nsop=%0d words=%0d cnt=%0d required 1/%0d/%0d",
                n_sop, cap.size(), cnt_eop, 3 + CS, exp_cnt);
        end
        d = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            d++;
            if (dout_sop) break;
        end
        nvec++;
        if (d != GAP + 2 || dout_sop !== 1'b1) begin
            nmis++;
            $display("FAIL b2b_gap: eop->sop %0d cycles sop=%b required %0d/1", d, dout_sop, GAP + 2);
        end
        cmd_start = 16'h0999;
        cmd_vld = 1'b0;
        collect();
        exp_cnt++;
        ex = build_exp(3, 16'h0020, 1'b0);
        bad = 0;
        for (int k = 0; k < cap.size() && k < ex.size(); k++) if (cap[k] !== ex[k]) bad++;
        nvec++;
        if (bad != 0 || cap.size() != ex.size() || cnt_eop !== 16'(exp_cnt)) begin
            nmis++;
            $display("FAIL b2b_second: words=%0d bad=%0d cnt=%0d required %0d/0/%0d",
                cap.size(), bad, cnt_eop, ex.size(), exp_cnt);
        end
    endtask

    task automatic test_csum();
        issue(4, 16'h000F, 1'b0, 1'b1);
        collect();
        exp_cnt++;
        nvec++;
        if (cap.size() != 4 + CS || cap[3] !== 16'h0012 || !eop_seen || err_eop !== 1'b1) begin
            nmis++;
            $display("FAIL csum_len: words=%0d w3=%h eop=%b err=%b required %0d/0012/1/1",
                cap.size(), cap[3], eop_seen, err_eop, 4 + CS);
        end
        if (CS == 1) begin
            nvec++;
            if (cap.size() < 5 || cap[4] !== 16'h0042) begin
                nmis++;
                $display("FAIL csum_word: words=%0d last=%h required 5/0042", cap.size(), cap[cap.size() - 1]);
            end
        end
        nvec++;
        if (cnt_eop !== 16'(exp_cnt) || err_bad != 0) begin
            nmis++;
            $display("FAIL csum_cnt: pkt_cnt=%0d err_off_eop=%0d required %0d/0", cnt_eop, err_bad, exp_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_vld = 1'b0;
        cmd_len = '0;
        cmd_start = '0;
        cmd_const = 1'b0;
        cmd_err = 1'b0;
        test_reset();
        test_mid_reset();
        test_incr();
        test_err_gap();
        test_const();
        test_wrap_short();
        test_back_to_back();
        test_csum();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
